// File: rtl/risc_pkg.sv
// Shared types for the risc_core accumulator CPU: opcodes, FSM states and decode helpers.
package risc_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  // True for the opcodes whose EXEC phase reads an operand from memory.
  function automatic logic is_mem_read(input opcode_t opcode);
    case (opcode)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/risc_if.sv
// Request/acknowledge memory bus between the core (master) and external memory (slave).
interface risc_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/risc_alu.sv
// Combinational accumulator ALU; in_a is the accumulator, in_b the memory operand.
module risc_alu
  import risc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             a_is_zero
);

  // Result select; the ADD carry falls off the top.
  always_comb begin
    alu_out = in_a;
    case (opcode)
      OP_ADD:  alu_out = in_a + in_b;
      OP_AND:  alu_out = in_a & in_b;
      OP_XOR:  alu_out = in_a ^ in_b;
      OP_LDA:  alu_out = in_b;
      default: alu_out = in_a;
    endcase
  end

  assign a_is_zero = (in_a == {WIDTH{1'b0}});

endmodule

// File: rtl/risc_core.sv
// Multi-cycle accumulator CPU (FETCH/DECODE/EXEC/HALT) driving an external req/ack memory bus.
module risc_core
  import risc_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resume,
  risc_if.master            bus,
  output logic              halt,
  output logic [AWIDTH-1:0] pc
);

  localparam logic [AWIDTH-1:0] PC_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_next;
  logic [AWIDTH-1:0] pc_r;
  logic [AWIDTH-1:0] pc_next;
  logic [DWIDTH-1:0] ir_r;
  logic [DWIDTH-1:0] ir_next;
  logic [DWIDTH-1:0] acc_r;
  logic [DWIDTH-1:0] acc_next;
  logic              halt_r;
  logic              req_s;
  logic              we_s;
  logic [AWIDTH-1:0] addr_s;
  opcode_t           opcode_s;
  logic [AWIDTH-1:0] operand_addr_s;
  logic [DWIDTH-1:0] alu_out_s;
  logic              acc_zero_s;

  assign opcode_s       = opcode_t'(ir_r[DWIDTH-1 -: 3]);
  assign operand_addr_s = ir_r[AWIDTH-1:0];

  risc_alu #(
    .WIDTH (DWIDTH)
  ) u_alu (
    .opcode    (opcode_s),
    .in_a      (acc_r),
    .in_b      (bus.mem_rdata),
    .alu_out   (alu_out_s),
    .a_is_zero (acc_zero_s)
  );

  // Next-state and bus decode; request/we/addr depend only on registered state, never on ack.
  always_comb begin
    state_next = state_r;
    pc_next    = pc_r;
    ir_next    = ir_r;
    acc_next   = acc_r;
    req_s      = 1'b0;
    we_s       = 1'b0;
    addr_s     = pc_r;
    case (state_r)
      FETCH: begin
        req_s = 1'b1;
        if (bus.mem_ack) begin
          ir_next    = bus.mem_rdata;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        pc_next    = pc_r + PC_ONE;
        state_next = EXEC;
      end
      EXEC: begin
        if (is_mem_read(opcode_s)) begin
          req_s  = 1'b1;
          addr_s = operand_addr_s;
          if (bus.mem_ack) begin
            acc_next   = alu_out_s;
            state_next = FETCH;
          end else begin
            state_next = EXEC;
          end
        end else begin
          case (opcode_s)
            OP_STO: begin
              req_s  = 1'b1;
              we_s   = 1'b1;
              addr_s = operand_addr_s;
              if (bus.mem_ack) begin
                state_next = FETCH;
              end else begin
                state_next = EXEC;
              end
            end
            OP_JMP: begin
              pc_next    = operand_addr_s;
              state_next = FETCH;
            end
            OP_SKZ: begin
              if (acc_zero_s) begin
                pc_next = pc_r + PC_ONE;
              end else begin
                pc_next = pc_r;
              end
              state_next = FETCH;
            end
            OP_HLT: begin
              state_next = HALT;
            end
            default: begin
              state_next = FETCH;
            end
          endcase
        end
      end
      HALT: begin
        if (resume) begin
          state_next = FETCH;
        end else begin
          state_next = HALT;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Architectural registers plus the registered halt flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FETCH;
      pc_r    <= {AWIDTH{1'b0}};
      ir_r    <= {DWIDTH{1'b0}};
      acc_r   <= {DWIDTH{1'b0}};
      halt_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      pc_r    <= pc_next;
      ir_r    <= ir_next;
      acc_r   <= acc_next;
      halt_r  <= (state_next == HALT);
    end
  end

  // Gating with rst drops an in-flight request the instant reset asserts.
  assign bus.mem_req   = req_s & rst;
  assign bus.mem_we    = we_s;
  assign bus.mem_addr  = addr_s;
  assign bus.mem_wdata = acc_r;
  assign halt          = halt_r;
  assign pc            = pc_r;

endmodule

// File: tb/tb_risc_core.sv
// Directed self-checking bench for risc_core with a req/ack memory responder.
module tb_risc_core;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          resume;
  logic          halt;
  logic [AW-1:0] pc;

  risc_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  risc_core #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .resume (resume),
    .bus    (bus),
    .halt   (halt),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory image and responder controls (written only by the stimulus process)
  logic [DW-1:0] mem [0:31];
  bit            wait_mode = 1'b0;
  bit            hold_we   = 1'b0;

  // Responder state and logs (written only by the responder)
  int            wr_count = 0;
  int            rd_count = 0;
  logic [AW-1:0] last_waddr;
  logic [DW-1:0] last_wdata;
  logic [AW-1:0] rd_log [0:63];
  bit            in_txn = 1'b0;
  int            wait_left = 0;
  bit            pend_commit = 1'b0;
  bit            pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] cap_addr;
  logic          cap_we;
  logic [DW-1:0] cap_wdata;

  // Acks are decided on the falling edge; a transfer is logged once the rising edge has taken it.
  always @(negedge clk) begin
    if (pend_commit && rst) begin
      if (pend_we) begin
        wr_count++;
        last_waddr = pend_addr;
        last_wdata = pend_data;
      end else begin
        if (rd_count < 64) rd_log[rd_count] = pend_addr;
        rd_count++;
      end
    end
    pend_commit  = 1'b0;
    bus.mem_ack  = 1'b0;
    if (!rst || !bus.mem_req) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn) begin
        in_txn    = 1'b1;
        cap_addr  = bus.mem_addr;
        cap_we    = bus.mem_we;
        cap_wdata = bus.mem_wdata;
        wait_left = wait_mode ? int'($urandom_range(3, 0)) : 0;
      end else begin
        check_eq("stable_addr", 32'(bus.mem_addr), 32'(cap_addr));
        check_eq("stable_we", 32'(bus.mem_we), 32'(cap_we));
        check_eq("stable_wdata", 32'(bus.mem_wdata), 32'(cap_wdata));
      end
      if (wait_left == 0 && !(hold_we && bus.mem_we)) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        pend_commit   = 1'b1;
        pend_we       = bus.mem_we;
        pend_addr     = bus.mem_addr;
        pend_data     = bus.mem_wdata;
        in_txn        = 1'b0;
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic hold_reset();
    rst    = 1'b0;
    resume = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Release just after a rising edge so the first bus cycle is a whole clock.
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic run_until_halt(input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc && halt !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("halt_reached", 32'(halt), 32'h1);
  endtask

  task automatic load_arith();
    clear_mem();
    mem[0]  = 8'hBE;
    mem[1]  = 8'h5F;
    mem[2]  = 8'hDD;
    mem[3]  = 8'h00;
    mem[30] = 8'hF0;
    mem[31] = 8'h25;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    int wr0;
    int rd0;
    bit found;

    // Reset state and the first fetch
    hold_reset();
    load_arith();
    #1;
    check_eq("rst_req", 32'(bus.mem_req), 32'h0);
    check_eq("rst_halt", 32'(halt), 32'h0);
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_we", 32'(bus.mem_we), 32'h0);
    check_eq("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    wr0 = wr_count;
    release_reset();
    check_eq("first_req", 32'(bus.mem_req), 32'h1);
    check_eq("first_addr", 32'(bus.mem_addr), 32'h0);
    check_eq("first_we", 32'(bus.mem_we), 32'h0);
    check_eq("first_halt", 32'(halt), 32'h0);
    check_eq("first_pc", 32'(pc), 32'h0);

    // LDA/ADD/STO/HLT with zero-wait memory
    run_until_halt(100, cyc);
    check_eq("arith_cycles", 32'(cyc), 32'd12);
    check_eq("arith_pc", 32'(pc), 32'd4);
    check_eq("arith_nwr", 32'(wr_count - wr0), 32'd1);
    check_eq("arith_waddr", 32'(last_waddr), 32'd29);
    check_eq("arith_wdata", 32'(last_wdata), 32'h15);

    // Same program with random wait states
    hold_reset();
    load_arith();
    wait_mode = 1'b1;
    wr0 = wr_count;
    release_reset();
    run_until_halt(300, cyc);
    check_eq("ws_pc", 32'(pc), 32'd4);
    check_eq("ws_nwr", 32'(wr_count - wr0), 32'd1);
    check_eq("ws_waddr", 32'(last_waddr), 32'd29);
    check_eq("ws_wdata", 32'(last_wdata), 32'h15);
    hold_reset();
    wait_mode = 1'b0;

    // SKZ with acc==0, then JMP
    clear_mem();
    mem[0] = 8'h20;
    mem[1] = 8'h00;
    mem[2] = 8'hE5;
    mem[5] = 8'h00;
    rd0 = rd_count;
    release_reset();
    run_until_halt(100, cyc);
    check_eq("skz_pc", 32'(pc), 32'd6);
    check_eq("skz_nfetch", 32'(rd_count - rd0), 32'd3);
    check_eq("skz_fetch0", 32'(rd_log[rd0]), 32'd0);
    check_eq("skz_fetch1", 32'(rd_log[rd0 + 1]), 32'd2);
    check_eq("jmp_fetch2", 32'(rd_log[rd0 + 2]), 32'd5);

    // Halt, ignored resume while running, then resume from HALT
    hold_reset();
    clear_mem();
    rd0 = rd_count;
    release_reset();
    resume = 1'b1;
    @(posedge clk);
    #2;
    resume = 1'b0;
    run_until_halt(50, cyc);
    check_eq("hlt_pc", 32'(pc), 32'd1);
    check_eq("hlt_nfetch", 32'(rd_count - rd0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hlt_stays", 32'(halt), 32'h1);
    check_eq("hlt_noreq", 32'(bus.mem_req), 32'h0);
    #1;
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    check_eq("resume_halt", 32'(halt), 32'h0);
    check_eq("resume_req", 32'(bus.mem_req), 32'h1);
    check_eq("resume_addr", 32'(bus.mem_addr), 32'd1);
    run_until_halt(50, cyc);
    check_eq("resume_pc", 32'(pc), 32'd2);
    check_eq("resume_nfetch", 32'(rd_count - rd0), 32'd2);
    check_eq("resume_fetch1", 32'(rd_log[rd0 + 1]), 32'd1);

    // Reset while a store is stalled
    hold_reset();
    clear_mem();
    mem[0]  = 8'hBE;
    mem[1]  = 8'hDD;
    mem[30] = 8'h7A;
    hold_we = 1'b1;
    wr0 = wr_count;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) found = 1'b1;
    end
    check_eq("sto_seen", 32'(found), 32'h1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("midrst_req", 32'(bus.mem_req), 32'h0);
    check_eq("midrst_pc", 32'(pc), 32'h0);
    repeat (2) @(posedge clk);
    hold_we = 1'b0;
    #1;
    check_eq("midrst_nowrite", 32'(wr_count - wr0), 32'd0);
    release_reset();
    check_eq("restart_req", 32'(bus.mem_req), 32'h1);
    check_eq("restart_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("restart_acc", 32'(bus.mem_wdata), 32'h0);
    run_until_halt(100, cyc);
    check_eq("restart_pc", 32'(pc), 32'd3);
    check_eq("restart_nwr", 32'(wr_count - wr0), 32'd1);
    check_eq("restart_wdata", 32'(last_wdata), 32'h7A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_core.md
# risc_core

Parametrised successor to the single-memory VeriRISC CPU. It executes the same 8-opcode accumulator ISA, but the fixed 3-bit phase counter is replaced by an explicit multi-cycle state machine. The on-chip memory is replaced by an external request/acknowledge bus, so instruction and operand accesses can take any number of wait states. A halted core restarts on a `resume` pulse without needing a reset.

## Interface
- `AWIDTH`, default 5: address width; the instruction address field is `ir[AWIDTH-1:0]`.
- `DWIDTH`, default 8: data and instruction width; must be ≥ AWIDTH+3. The opcode is `ir[DWIDTH-1:DWIDTH-3]`, and bits between the opcode and the address field are ignored.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `resume` in 1: leave HALT; sampled only in HALT.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr` out AWIDTH: transaction address.
- `mem_wdata` out DWIDTH: write data (the accumulator).
- `mem_rdata` in DWIDTH: read data; valid when `mem_ack`=1.
- `mem_ack` in 1: transaction complete in this cycle.
- `halt` out 1: core is in HALT.
- `pc` out AWIDTH: program counter, for debug and bench.

## Operation
- **Opcodes:** HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- **FETCH**
  - `mem_req`=1, `mem_we`=0, `mem_addr`=pc.
  - On `mem_ack`: `ir`←`mem_rdata`, go to DECODE.
- **DECODE**
  - pc←pc+1, wrapping modulo 2^AWIDTH; go to EXEC.
- **EXEC**
  - ADD/AND/XOR/LDA: `mem_req`=1, `mem_we`=0, `mem_addr`=ir address field. On `mem_ack`: acc←acc op `mem_rdata` (LDA: acc←`mem_rdata`), then FETCH.
  - ADD is modulo 2^DWIDTH; the carry is discarded.
  - STO: `mem_req`=1, `mem_we`=1, `mem_wdata`=acc. On `mem_ack`, go to FETCH.
  - JMP: pc←ir address field, go to FETCH.
  - SKZ: if acc==0 then pc←pc+1 (wrapping). Go to FETCH.
  - HLT: go to HALT.
- **HALT**
  - `halt`=1, no requests.
  - `resume`=1 → FETCH at the current pc, i.e. the instruction after HLT.
- **Memory handshake rules**
  - Once `mem_req` rises, `mem_we`, `mem_addr` and `mem_wdata` stay stable until the cycle in which `mem_ack`=1.
  - `mem_ack` in the same cycle as `mem_req` is legal: a zero-wait access completes in one cycle.
  - `mem_ack` while `mem_req`=0 is ignored.
  - `mem_req` falls in the cycle after ack, except that FETCH→DECODE→EXEC back-to-back produces separate requests.
- **Bus outputs:** `mem_req`, `mem_we` and `mem_addr` are decoded from the state register and `ir`/pc only, never combinationally from `mem_ack`.
- **`resume` outside HALT:** ignored.

## Timing
- **Reset values:** state=FETCH, pc=0, acc=0, ir=0, `halt`=0, `mem_we`=0, `mem_wdata`=0.
  - `mem_req` is forced to 0 while `rst`=0.
  - `mem_req`=1 with `mem_addr`=0 in the first cycle after `rst` rises.
- **Zero-wait latency:**
  - ADD/AND/XOR/LDA/STO: 3 cycles (FETCH, DECODE, EXEC).
  - JMP/SKZ: 3 cycles.
  - HLT: `halt`=1 on the 4th cycle after its fetch begins.
- **Wait states:** each adds exactly one cycle to FETCH or EXEC.
- **SKZ:** tests acc as it stands in EXEC, i.e. after all earlier instructions have retired.
- **Reset mid-transaction:** the request is abandoned immediately (`mem_req`→0 asynchronously), with no write retry. A late `mem_ack` after reset is ignored.
- **Resume:** `resume` and HALT entry never coincide. The first HALT cycle samples `resume`, and FETCH follows one cycle later.

## Structure
- **`risc_pkg`:** opcode enum (3-bit), state enum (FETCH, DECODE, EXEC, HALT), and a helper `is_mem_read(opcode)`.
- **Sub-module `risc_alu`:** combinational; inputs opcode, `in_a`, `in_b`, parameter WIDTH; outputs `alu_out` and `a_is_zero`.
- **`risc_core` itself:** FSM, pc, ir, acc and bus outputs.

## Test plan
All scenarios use AWIDTH=5, DWIDTH=8.
- **Reset/first fetch:** release `rst` → next cycle `mem_req`=1, `mem_addr`=0, `mem_we`=0, `halt`=0, pc=0.
- **Arithmetic and store, zero-wait memory model:**
  - Program: mem[0]=0xBE (LDA 30), mem[1]=0x5F (ADD 31), mem[2]=0xDD (STO 29), mem[3]=0x00 (HLT); mem[30]=0xF0, mem[31]=0x25.
  - Required: one write to addr 29 with data 0x15 (wrap); `halt`=1 with pc=4; `halt` rises 12 cycles after the first request.
- **Wait states:** same program with 0–3 random wait cycles per access → identical memory contents. `mem_addr`/`mem_we`/`mem_wdata` are stable across every wait cycle, which the bench checks with an assertion.
- **Skip and jump:**
  - Program: mem[0]=0x20 (SKZ), mem[1]=0x00 (HLT), mem[2]=0xE5 (JMP 5), mem[5]=0x00 (HLT).
  - Required: acc=0 after reset, so the instruction at address 1 is never fetched; the next fetch address after 2 is 5; halts with pc=6.
- **Halt/resume:**
  - Program: mem[0]=HLT, mem[1]=HLT.
  - `resume` pulse while running → no effect.
  - Pulse in HALT → fetch at addr 1, then HALT again with pc=2.
- **Reset mid-access:** hold `mem_ack`=0 during the STO, assert `rst` → `mem_req`=0 in the same cycle, no write observed. After release, the fetch restarts at addr 0 with acc=0.
